// File: rtl/kernel_frame_ctrl_pkg.sv
// Shared definitions for the kernel frame sequencer.
//   - Beat type encodings carried on dtypei/dtypeo and the pixel mask.
//   - Header word indices for the image geometry fields.
//   - FSM state encoding and header index width.
//   - geom_legal(): whether the kernel can process a frame of the given geometry.
package kernel_frame_ctrl_pkg;

  localparam int unsigned DtypeWidth = 4;

  localparam logic [DtypeWidth-1:0] DtypeNone        = 4'h0;
  localparam logic [DtypeWidth-1:0] DtypeFrameStart  = 4'h1;
  localparam logic [DtypeWidth-1:0] DtypeFrameEnd    = 4'h2;
  localparam logic [DtypeWidth-1:0] DtypeRowStart    = 4'h3;
  localparam logic [DtypeWidth-1:0] DtypeRowEnd      = 4'h4;
  localparam logic [DtypeWidth-1:0] DtypeHeaderStart = 4'h5;
  localparam logic [DtypeWidth-1:0] DtypeHeader      = 4'h6;
  // Any type with the MSB set is a pixel beat.
  localparam logic [DtypeWidth-1:0] DtypePixel       = 4'h8;
  localparam logic [DtypeWidth-1:0] DtypePixelMask   = 4'h8;

  localparam int unsigned HdrIdxWidth = 2;
  localparam logic [HdrIdxWidth-1:0] ImageNumCols = 2'd0;
  localparam logic [HdrIdxWidth-1:0] ImageNumRows = 2'd1;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StHeader = 2'd1;
  localparam logic [1:0] StFrame  = 2'd2;
  localparam logic [1:0] StRow    = 2'd3;

  function automatic logic geom_legal(input int unsigned cols, input int unsigned rows,
                                      input int unsigned ksize, input int unsigned max_cols);
    return (cols >= ksize) && (cols <= max_cols) && (rows >= ksize);
  endfunction

endpackage

// File: rtl/kernel_frame_ctrl_frame_geom_checker.sv
// Geometry checker: captures the header geometry, counts pixels per row and rows per
// frame, counts completed frames and holds the four sticky error flags.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   dvi, dtypei           input beat valid and type
//   meta_datai            header word (captured on header beats)
//   state_i               current sequencer FSM state
//   err_clear_i           clears all sticky errors (a same-cycle set wins)
//   geom_evt_i/proto_evt_i error events detected by the sequencer
//   num_cols_o/num_rows_o captured geometry
//   frame_count_o         completed frames, wrapping
//   *_err_o               sticky error flags
module frame_geom_checker
  import kernel_frame_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned NUM_COLS_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dvi,
  input  logic [DtypeWidth-1:0] dtypei,
  input  logic [DATA_WIDTH-1:0] meta_datai,
  input  logic [1:0]            state_i,
  input  logic                  err_clear_i,
  input  logic                  geom_evt_i,
  input  logic                  proto_evt_i,
  output logic [DATA_WIDTH-1:0] num_cols_o,
  output logic [DATA_WIDTH-1:0] num_rows_o,
  output logic [15:0]           frame_count_o,
  output logic                  geom_err_o,
  output logic                  col_err_o,
  output logic                  row_err_o,
  output logic                  proto_err_o
);

  logic in_row, in_frame;
  logic hdr_start, hdr_beat, row_start, pix, row_end, frame_start, frame_end, frame_done;
  logic [HdrIdxWidth-1:0]    hdr_idx_q, hdr_idx_d;
  logic [DATA_WIDTH-1:0]     num_cols_q, num_cols_d, num_rows_q, num_rows_d;
  logic                      hdr_valid_q, hdr_valid_d;
  logic [NUM_COLS_WIDTH-1:0] col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
  logic [15:0]               frame_count_q, frame_count_d;
  // {proto, row, col, geom}
  logic [3:0]                err_q, err_d, err_set;

  always_comb begin
    in_row      = state_i == StRow;
    in_frame    = state_i == StFrame;
    hdr_start   = dvi && dtypei == DtypeHeaderStart && (state_i == StIdle || state_i == StHeader);
    hdr_beat    = dvi && dtypei == DtypeHeader && state_i == StHeader;
    row_start   = dvi && dtypei == DtypeRowStart && (in_frame || in_row);
    pix         = dvi && in_row && ((dtypei & DtypePixelMask) != '0);
    row_end     = dvi && in_row && dtypei == DtypeRowEnd;
    frame_start = dvi && dtypei == DtypeFrameStart;
    frame_done  = dvi && in_frame && dtypei == DtypeFrameEnd;
    // A FRAME_END inside a row still closes the header window, but skips the checks.
    frame_end   = dvi && (in_frame || in_row) && dtypei == DtypeFrameEnd;

    hdr_idx_d     = hdr_idx_q;
    num_cols_d    = num_cols_q;
    num_rows_d    = num_rows_q;
    hdr_valid_d   = hdr_valid_q;
    col_cnt_d     = col_cnt_q;
    row_cnt_d     = row_cnt_q;
    frame_count_d = frame_count_q;

    if (hdr_start) begin
      hdr_idx_d = '0;
    end else if (hdr_beat) begin
      if (hdr_idx_q == ImageNumCols) num_cols_d = meta_datai;
      if (hdr_idx_q == ImageNumRows) num_rows_d = meta_datai;
      if (hdr_idx_q != '1) hdr_idx_d = hdr_idx_q + 1'b1;
      hdr_valid_d = 1'b1;
    end
    if (frame_end) hdr_valid_d = 1'b0;

    if (row_start) begin
      col_cnt_d = '0;
    end else if (pix && col_cnt_q != '1) begin
      col_cnt_d = col_cnt_q + 1'b1;
    end

    if (frame_start) begin
      row_cnt_d = '0;
    end else if (row_end && row_cnt_q != '1) begin
      row_cnt_d = row_cnt_q + 1'b1;
    end

    if (frame_done) frame_count_d = frame_count_q + 16'd1;

    err_set = {proto_evt_i,
               frame_done && hdr_valid_q && (DATA_WIDTH'(row_cnt_q) != num_rows_q),
               row_end && hdr_valid_q && (DATA_WIDTH'(col_cnt_q) != num_cols_q),
               geom_evt_i};
    err_d   = (err_clear_i ? 4'b0000 : err_q) | err_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hdr_idx_q     <= '0;
      num_cols_q    <= '0;
      num_rows_q    <= '0;
      hdr_valid_q   <= 1'b0;
      col_cnt_q     <= '0;
      row_cnt_q     <= '0;
      frame_count_q <= '0;
      err_q         <= '0;
    end else begin
      hdr_idx_q     <= hdr_idx_d;
      num_cols_q    <= num_cols_d;
      num_rows_q    <= num_rows_d;
      hdr_valid_q   <= hdr_valid_d;
      col_cnt_q     <= col_cnt_d;
      row_cnt_q     <= row_cnt_d;
      frame_count_q <= frame_count_d;
      err_q         <= err_d;
    end
  end

  assign num_cols_o    = num_cols_q;
  assign num_rows_o    = num_rows_q;
  assign frame_count_o = frame_count_q;
  assign geom_err_o    = err_q[0];
  assign col_err_o     = err_q[1];
  assign row_err_o     = err_q[2];
  assign proto_err_o   = err_q[3];

endmodule

// File: rtl/kernel_frame_ctrl.sv
// Sequencer in front of the row-buffered kernel. Passes the pixel stream through with one
// cycle of latency, tracks the framing with a small FSM, and switches the kernel enable
// only at frame boundaries, forcing bypass for frames the kernel cannot handle.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   dvi/dtypei/datai/meta_datai       input stream beat
//   enable_req                        host request for kernel processing
//   err_clear                         pulse clearing the sticky errors
//   dvo/dtypeo/datao/meta_datao       registered copy of the input beat
//   kernel_enable                     kernel enable, aligned with the output beat
//   busy                              FSM not idle
//   frame_count                       completed frames (wraps)
//   geom_err/col_err/row_err/proto_err sticky errors
module kernel_frame_ctrl
  import kernel_frame_ctrl_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE    = 3,
  parameter int unsigned PIXEL_WIDTH    = 10,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned MAX_COLS       = 1288,
  parameter int unsigned NUM_COLS_WIDTH = 11
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dvi,
  input  logic [DtypeWidth-1:0]  dtypei,
  input  logic [PIXEL_WIDTH-1:0] datai,
  input  logic [DATA_WIDTH-1:0]  meta_datai,
  input  logic                   enable_req,
  input  logic                   err_clear,
  output logic                   dvo,
  output logic [DtypeWidth-1:0]  dtypeo,
  output logic [PIXEL_WIDTH-1:0] datao,
  output logic [DATA_WIDTH-1:0]  meta_datao,
  output logic                   kernel_enable,
  output logic                   busy,
  output logic [15:0]            frame_count,
  output logic                   geom_err,
  output logic                   col_err,
  output logic                   row_err,
  output logic                   proto_err
);

  logic [1:0]             state_q, state_d;
  logic                   is_pixel, frame_start, proto_evt, geom_evt, geom_ok;
  logic                   ken_q, ken_d;
  logic                   dvo_q;
  logic [DtypeWidth-1:0]  dtypeo_q;
  logic [PIXEL_WIDTH-1:0] datao_q;
  logic [DATA_WIDTH-1:0]  meta_q;
  logic [DATA_WIDTH-1:0]  num_cols, num_rows;

  always_comb begin
    is_pixel    = (dtypei & DtypePixelMask) != '0;
    frame_start = dvi && dtypei == DtypeFrameStart;
    geom_ok     = geom_legal(32'(num_cols), 32'(num_rows), KERNEL_SIZE, MAX_COLS);
    geom_evt    = frame_start && enable_req && !geom_ok;

    state_d   = state_q;
    proto_evt = 1'b0;
    if (dvi) begin
      if (is_pixel) begin
        proto_evt = state_q != StRow;
      end else begin
        case (dtypei)
          DtypeHeaderStart: begin
            if (state_q == StIdle || state_q == StHeader) state_d = StHeader;
          end
          DtypeFrameStart: begin
            // From FRAME/ROW this restarts the frame.
            state_d   = StFrame;
            proto_evt = state_q == StFrame || state_q == StRow;
          end
          DtypeRowStart: begin
            if (state_q == StFrame) state_d = StRow;
            else if (state_q == StRow) proto_evt = 1'b1;
          end
          DtypeRowEnd: begin
            if (state_q == StRow) state_d = StFrame;
            else proto_evt = 1'b1;
          end
          DtypeFrameEnd: begin
            if (state_q == StFrame) begin
              state_d = StIdle;
            end else if (state_q == StRow) begin
              state_d   = StIdle;
              proto_evt = 1'b1;
            end
          end
          default: ;
        endcase
      end
    end

    // Enable only moves on a FRAME_START beat or between frames, so a frame never
    // sees the kernel switch mid-way.
    ken_d = ken_q;
    if (frame_start || (dvi && state_q == StIdle)) ken_d = enable_req && geom_ok;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ken_q    <= 1'b0;
      dvo_q    <= 1'b0;
      dtypeo_q <= '0;
      datao_q  <= '0;
      meta_q   <= '0;
    end else begin
      state_q  <= state_d;
      ken_q    <= ken_d;
      dvo_q    <= dvi;
      dtypeo_q <= dtypei;
      datao_q  <= datai;
      meta_q   <= meta_datai;
    end
  end

  frame_geom_checker #(
    .DATA_WIDTH     (DATA_WIDTH),
    .NUM_COLS_WIDTH (NUM_COLS_WIDTH)
  ) u_checker (
    .clk           (clk),
    .reset         (reset),
    .dvi           (dvi),
    .dtypei        (dtypei),
    .meta_datai    (meta_datai),
    .state_i       (state_q),
    .err_clear_i   (err_clear),
    .geom_evt_i    (geom_evt),
    .proto_evt_i   (proto_evt),
    .num_cols_o    (num_cols),
    .num_rows_o    (num_rows),
    .frame_count_o (frame_count),
    .geom_err_o    (geom_err),
    .col_err_o     (col_err),
    .row_err_o     (row_err),
    .proto_err_o   (proto_err)
  );

  assign dvo           = dvo_q;
  assign dtypeo        = dtypeo_q;
  assign datao         = datao_q;
  assign meta_datao    = meta_q;
  assign kernel_enable = ken_q;
  assign busy          = state_q != StIdle;

endmodule

// File: tb/tb_kernel_frame_ctrl.sv
// Bench for kernel_frame_ctrl: every driven beat is pushed to a scoreboard with its expected
// busy/kernel_enable; a monitor pops and compares one cycle later. Scenario tasks check the
// sticky flags and frame count directly.
module tb_kernel_frame_ctrl;
  import kernel_frame_ctrl_pkg::*;

  localparam int unsigned KS = 3;
  localparam int unsigned PW = 10;
  localparam int unsigned DW = 16;
  localparam int unsigned MC = 1288;

  logic                  clk = 1'b0;
  logic                  reset, dvi, enable_req, err_clear;
  logic [DtypeWidth-1:0] dtypei, dtypeo;
  logic [PW-1:0]         datai, datao;
  logic [DW-1:0]         meta_datai, meta_datao;
  logic                  dvo, kernel_enable, busy;
  logic [15:0]           frame_count;
  logic                  geom_err, col_err, row_err, proto_err;

  always #5 clk = ~clk;

  kernel_frame_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .dvi           (dvi),
    .dtypei        (dtypei),
    .datai         (datai),
    .meta_datai    (meta_datai),
    .enable_req    (enable_req),
    .err_clear     (err_clear),
    .dvo           (dvo),
    .dtypeo        (dtypeo),
    .datao         (datao),
    .meta_datao    (meta_datao),
    .kernel_enable (kernel_enable),
    .busy          (busy),
    .frame_count   (frame_count),
    .geom_err      (geom_err),
    .col_err       (col_err),
    .row_err       (row_err),
    .proto_err     (proto_err)
  );

  typedef struct {
    logic                  dv;
    logic [DtypeWidth-1:0] dt;
    logic [PW-1:0]         d;
    logic [DW-1:0]         m;
    bit                    chk_ken;
    bit                    ken;
    bit                    busy;
  } beat_t;

  beat_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  bit    exp_busy = 1'b0;
  bit    exp_ken  = 1'b0;
  bit    chk_ken  = 1'b0;
  int    exp_fc   = 0;

  // Scoreboard monitor: compares each output beat against what was driven a cycle earlier.
  always @(posedge clk) begin
    beat_t e;
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      n_checks++;
      if ({dvo, dtypeo, datao, meta_datao} !== {e.dv, e.dt, e.d, e.m}) begin
        n_fail++;
        $display("FAIL passthru: got %0h/%0h/%0h/%0h expected %0h/%0h/%0h/%0h", dvo, dtypeo,
                 datao, meta_datao, e.dv, e.dt, e.d, e.m);
      end
      n_checks++;
      if (busy !== e.busy) begin
        n_fail++;
        $display("FAIL busy: got %b expected %b (dtype %0h)", busy, e.busy, e.dt);
      end
      if (e.chk_ken) begin
        n_checks++;
        if (kernel_enable !== e.ken) begin
          n_fail++;
          $display("FAIL kernel_enable: got %b expected %b (dtype %0h)", kernel_enable, e.ken,
                   e.dt);
        end
      end
    end
  end

  task automatic send(input bit dv, input logic [DtypeWidth-1:0] dt, input logic [DW-1:0] meta,
                      input bit clr = 1'b0);
    beat_t b;
    @(negedge clk);
    dvi        = dv;
    dtypei     = dt;
    datai      = PW'($urandom);
    meta_datai = meta;
    err_clear  = clr;
    b.dv = dv; b.dt = dt; b.d = datai; b.m = meta;
    b.chk_ken = chk_ken; b.ken = exp_ken; b.busy = exp_busy;
    sb.push_back(b);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset      = 1'b1;
    dvi        = 1'b1;
    dtypei     = DtypePixel;
    datai      = '1;
    meta_datai = '1;
    err_clear  = 1'b0;
    sb.delete();
    exp_busy = 1'b0; chk_ken = 1'b0; exp_ken = 1'b0; exp_fc = 0;
    @(posedge clk);
    #2;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    dvi   = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd();
    return DW'($urandom);
  endfunction

  // Full frame: header, frame start, rows of pixels, frame end, one idle beat.
  task automatic run_frame(input int hc, input int hr, input int nrows, input int npix,
                           input bit en, input int drop_row);
    bit legal;
    legal = (hc >= int'(KS)) && (hc <= int'(MC)) && (hr >= int'(KS));
    enable_req = en;
    chk_ken    = 1'b0;
    exp_busy   = 1'b1;
    send(1, DtypeHeaderStart, rnd());
    send(1, DtypeHeader, DW'(hc));
    send(1, DtypeHeader, DW'(hr));
    exp_ken = en && legal;
    chk_ken = 1'b1;
    send(1, DtypeFrameStart, rnd());
    for (int r = 0; r < nrows; r++) begin
      if (r == drop_row) enable_req = 1'b0;
      send(1, DtypeRowStart, rnd());
      for (int p = 0; p < npix; p++) send(1, (p % 2 == 0) ? DtypePixel : 4'h9, rnd());
      send(1, DtypeRowEnd, rnd());
    end
    exp_busy = 1'b0;
    send(1, DtypeFrameEnd, rnd());
    if (hr == nrows) exp_fc++;
    else exp_fc++;
    chk_ken = 1'b0;
    send(0, DtypeNone, rnd());
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if ({dvo, dtypeo, datao, meta_datao} !== '0) begin
      n_fail++;
      $display("FAIL reset_stream: got %0h/%0h/%0h/%0h expected all 0", dvo, dtypeo, datao,
               meta_datao);
    end
    n_checks++;
    if ({kernel_enable, busy} !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got ken=%b busy=%b expected 0 0", kernel_enable, busy);
    end
    n_checks++;
    if (frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_frame_count: got %0d expected 0", frame_count);
    end
    n_checks++;
    if ({geom_err, col_err, row_err, proto_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_errs: got %b expected 0000", {geom_err, col_err, row_err, proto_err});
    end
    release_reset();
  endtask

  task automatic test_basic();
    run_frame(8, 6, 6, 8, 1'b1, -1);
    @(posedge clk); #2;
    n_checks++;
    if (frame_count !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL basic_frame_count: got %0d expected %0d", frame_count, exp_fc);
    end
    n_checks++;
    if ({geom_err, col_err, row_err, proto_err} !== 4'b0000) begin
      n_fail++;
      $display("FAIL basic_errs: got %b expected 0000", {geom_err, col_err, row_err, proto_err});
    end
  endtask

  // Enable dropped mid-frame holds until the next frame, which is then bypassed.
  task automatic test_enable_hold();
    run_frame(8, 6, 6, 8, 1'b1, 3);
    run_frame(8, 6, 6, 8, 1'b0, -1);
    @(posedge clk); #2;
    n_checks++;
    if (frame_count !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL hold_frame_count: got %0d expected %0d", frame_count, exp_fc);
    end
  endtask

  task automatic test_geom();
    int hc_t[6] = '{1300, 2, 3, 1288, 8, 2};
    int hr_t[6] = '{3, 3, 3, 3, 2, 3};
    bit en_t[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit exp_g;
    for (int i = 0; i < 6; i++) begin
      exp_busy = 1'b0;
      send(0, DtypeNone, rnd(), 1'b1);
      run_frame(hc_t[i], hr_t[i], hr_t[i], hc_t[i], en_t[i], -1);
      exp_g = en_t[i] && !((hc_t[i] >= int'(KS)) && (hc_t[i] <= int'(MC)) &&
                           (hr_t[i] >= int'(KS)));
      @(posedge clk); #2;
      n_checks++;
      if (geom_err !== exp_g) begin
        n_fail++;
        $display("FAIL geom_err[%0d] cols=%0d rows=%0d: got %b expected %b", i, hc_t[i],
                 hr_t[i], geom_err, exp_g);
      end
      n_checks++;
      if ({col_err, row_err, proto_err} !== 3'b000) begin
        n_fail++;
        $display("FAIL geom_other_errs[%0d]: got %b expected 000", i,
                 {col_err, row_err, proto_err});
      end
    end
  endtask

  task automatic test_col_row_err();
    exp_busy = 1'b0;
    chk_ken  = 1'b0;
    send(0, DtypeNone, rnd(), 1'b1);
    enable_req = 1'b1;
    exp_busy   = 1'b1;
    send(1, DtypeHeaderStart, rnd());
    send(1, DtypeHeader, 16'd8);
    send(1, DtypeHeader, 16'd6);
    exp_ken = 1'b1;
    chk_ken = 1'b1;
    send(1, DtypeFrameStart, rnd());
    for (int r = 0; r < 5; r++) begin
      send(1, DtypeRowStart, rnd());
      for (int p = 0; p < ((r == 1) ? 7 : 8); p++) send(1, DtypePixel, rnd());
      send(1, DtypeRowEnd, rnd());
      if (r == 1) begin
        @(posedge clk); #2;
        n_checks++;
        if (col_err !== 1'b1) begin
          n_fail++;
          $display("FAIL col_err_short_row: got %b expected 1", col_err);
        end
        send(0, DtypeNone, rnd(), 1'b1);
        @(posedge clk); #2;
        n_checks++;
        if (col_err !== 1'b0) begin
          n_fail++;
          $display("FAIL col_err_clear: got %b expected 0", col_err);
        end
      end
    end
    // Clear coincides with the row-count error: the set must win.
    exp_busy = 1'b0;
    send(1, DtypeFrameEnd, rnd(), 1'b1);
    exp_fc++;
    @(posedge clk); #2;
    n_checks++;
    if ({geom_err, col_err, row_err, proto_err} !== 4'b0010) begin
      n_fail++;
      $display("FAIL row_err_set_wins: got %b expected 0010",
               {geom_err, col_err, row_err, proto_err});
    end
    n_checks++;
    if (frame_count !== 16'(exp_fc)) begin
      n_fail++;
      $display("FAIL rowerr_frame_count: got %0d expected %0d", frame_count, exp_fc);
    end
    chk_ken = 1'b0;
    send(0, DtypeNone, rnd());
  endtask

  task automatic test_proto();
    exp_busy = 1'b0;
    chk_ken  = 1'b0;
    send(0, DtypeNone, rnd(), 1'b1);
    enable_req = 1'b1;
    exp_busy   = 1'b1;
    send(1, DtypeHeaderStart, rnd());
    send(1, DtypeHeader, 16'd8);
    send(1, DtypeHeader, 16'd6);
    exp_ken = 1'b1;
    chk_ken = 1'b1;
    send(1, DtypeFrameStart, rnd());
    send(1, DtypeRowStart, rnd());
    for (int p = 0; p < 3; p++) send(1, DtypePixel, rnd());
    send(1, DtypeRowStart, rnd());
    for (int p = 0; p < 8; p++) send(1, DtypePixel, rnd());
    send(1, DtypeRowEnd, rnd());
    @(posedge clk); #2;
    n_checks++;
    if ({proto_err, col_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL proto_double_row_start: got proto=%b col=%b expected 1 0", proto_err,
               col_err);
    end
    send(1, DtypeRowStart, rnd());
    send(1, DtypePixel, rnd());
    send(1, DtypePixel, rnd());
    exp_busy = 1'b0;
    send(1, DtypeFrameEnd, rnd());
    @(posedge clk); #2;
    n_checks++;
    if ({busy, proto_err, row_err, col_err} !== 4'b0100) begin
      n_fail++;
      $display("FAIL proto_frame_end_in_row: got busy=%b proto=%b row=%b col=%b expected 0100",
               busy, proto_err, row_err, col_err);
    end
    chk_ken = 1'b0;
    send(0, DtypeNone, rnd(), 1'b1);
    @(posedge clk); #2;
    n_checks++;
    if (proto_err !== 1'b0) begin
      n_fail++;
      $display("FAIL proto_clear: got %b expected 0", proto_err);
    end
    send(1, DtypePixel, rnd());
    @(posedge clk); #2;
    n_checks++;
    if (proto_err !== 1'b1) begin
      n_fail++;
      $display("FAIL proto_pixel_idle: got %b expected 1", proto_err);
    end
    send(0, DtypeNone, rnd(), 1'b1);
    send(1, DtypeRowEnd, rnd());
    @(posedge clk); #2;
    n_checks++;
    if ({proto_err, row_err} !== 2'b10) begin
      n_fail++;
      $display("FAIL proto_row_end_idle: got proto=%b row=%b expected 1 0", proto_err, row_err);
    end
  endtask

  task automatic test_reset_mid();
    exp_busy = 1'b1;
    chk_ken  = 1'b0;
    enable_req = 1'b1;
    send(1, DtypeHeaderStart, rnd());
    send(1, DtypeHeader, 16'd8);
    send(1, DtypeHeader, 16'd6);
    send(1, DtypeFrameStart, rnd());
    send(1, DtypeRowStart, rnd());
    for (int p = 0; p < 3; p++) send(1, DtypePixel, rnd());
    apply_reset();
    n_checks++;
    if ({dvo, dtypeo, datao, meta_datao, kernel_enable, busy} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got dvo=%b dt=%0h d=%0h m=%0h ken=%b busy=%b expected 0",
               dvo, dtypeo, datao, meta_datao, kernel_enable, busy);
    end
    n_checks++;
    if ({frame_count, geom_err, col_err, row_err, proto_err} !== '0) begin
      n_fail++;
      $display("FAIL midreset_status: got fc=%0d errs=%b expected 0", frame_count,
               {geom_err, col_err, row_err, proto_err});
    end
    release_reset();
    send(0, DtypeNone, rnd());
    run_frame(8, 6, 6, 8, 1'b1, -1);
    @(posedge clk); #2;
    n_checks++;
    if ({frame_count, geom_err, col_err, row_err, proto_err} !== {16'd1, 4'b0000}) begin
      n_fail++;
      $display("FAIL midreset_clean_frame: got fc=%0d errs=%b expected fc=1 errs=0000",
               frame_count, {geom_err, col_err, row_err, proto_err});
    end
  endtask

  initial begin
    reset      = 1'b0;
    dvi        = 1'b0;
    dtypei     = '0;
    datai      = '0;
    meta_datai = '0;
    enable_req = 1'b0;
    err_clear  = 1'b0;
    test_reset();
    test_basic();
    test_enable_hold();
    test_geom();
    test_col_row_err();
    test_proto();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d beats left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
